seq_barrel_shifter_4bit: RTL and testbench
==========================================

# seq_barrel_shifter_4bit

Multi-cycle, handshaked counterpart of the combinational 4-bit barrel shifter. It accepts an operand, a shift amount and a direction on a `start` pulse. It then shifts or rotates one bit position per clock and returns the registered result with a one-cycle `done` strobe. It serves datapaths that need the shifter's function behind a start/busy/done interface with registered outputs. It is also the verification companion for the combinational shifter: a rotate in one direction followed by the same amount in the other direction must restore the operand.

## Interface
- `WIDTH`, default 4: operand and result width.
- `SHW`, default 2: shift-amount width; amounts range from 0 to 2^SHW−1.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request; sampled only in IDLE.
- `D` input, WIDTH bits: operand, captured when `start` is accepted.
- `S` input, SHW bits: shift amount, captured when `start` is accepted.
- `dir` input, 1 bit: 0 shifts left (toward MSB), 1 shifts right; captured when `start` is accepted.
- `mode` input, 1 bit: 0 rotates, 1 performs a logical shift with zero fill; captured when `start` is accepted.
- `Y` output, WIDTH bits: registered result; updated only at completion.
- `busy` output, 1 bit: high while an operation is in progress.
- `done` output, 1 bit: single-cycle strobe when `Y` is updated.

## Operation
- States are IDLE and SHIFT, plus an internal working register `wr[WIDTH-1:0]` and a down-counter `cnt[SHW-1:0]`.
- **IDLE, `start`=1 at an edge:** load `wr`←`D`, `cnt`←`S`, and latch `dir` and `mode`. Set `busy`=1 and go to SHIFT.
- **IDLE, `start`=0:** hold all state.
- **SHIFT, `cnt`≠0 at an edge:** shift `wr` by one position in the latched direction and decrement `cnt`.
  - Rotate left: {wr[W-2:0], wr[W-1]}.
  - Rotate right: {wr[0], wr[W-1:1]}.
  - Logical shift: the vacated bit is 0.
- **SHIFT, `cnt`==0 at an edge:** `Y`←`wr`, `done`←1, `busy`←0, go to IDLE.
- `done` is deasserted at the next edge unconditionally.
- S=0 passes the operand through: `Y`=`D` after two edges.
- `start` is ignored while `busy`=1. Inputs may change freely after acceptance without affecting the operation.
- A `start` sampled in the cycle where `done`=1 is accepted, since the block is already in IDLE. Holding `start` high gives back-to-back operations.
- `Y` holds its last value between operations. Intermediate `wr` values are never visible on `Y`.
- A logical shift by S ≥ WIDTH yields all zeros. This cannot occur at the defaults, but the parameterisation must handle it.

## Timing
- **Reset values** (asynchronous, while `rst_n`=0): state=IDLE, `Y`=0, `busy`=0, `done`=0, `wr`=0, `cnt`=0.
- **Reset mid-operation:** aborts the operation with no `done` and `Y`=0. The first `start` after `rst_n` rises behaves normally.
- **Latency:** with `start` accepted at edge k, `busy`=1 from edge k and `done`=1 and `Y` valid from edge k+S+1 to edge k+S+2.
- **Throughput:** one operation every S+2 cycles with `start` held high.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Rotate left:** D=1101, mode=0, dir=0, S=00/01/10/11 → Y=1101/1011/0111/1110. `done` arrives 1/2/3/4 cycles after the accept edge.
- **Rotate right:** D=1101, mode=0, dir=1, S=01/10/11 → Y=1110/0111/1011. Then start with D=Y, dir=0 and the same S; each must return 1101 (round trip).
- **Logical shift:** D=1101, mode=1. dir=0, S=10 → Y=0100. dir=1, S=01 → Y=0110. dir=1, S=11 → Y=0001.
- **Start while busy:** D=1101, S=11, dir=0, mode=0. Pulse `start` again one cycle later with D=0000. The result is 1110, exactly one `done` is produced, and the second request is dropped.
- **Back-to-back:** hold `start`=1 with S=01, dir=0, mode=0 and D=0001, then D=0010 presented from the `done` cycle onward. Y=0010 then Y=0100, with `done` strobes 3 cycles apart.
- **Reset mid-operation:** D=1101, S=11. Assert `rst_n`=0 asynchronously two cycles after the accept edge. Y=0, `busy`=0 and `done`=0 immediately, and no `done` appears afterward. A fresh operation then completes correctly.

Source files
------------

// File: rtl/seq_barrel_shifter_4bit.sv
// Sequential barrel shifter: captures an operand on start, rotates or logically
// shifts it one bit per clock, then presents the result on Y with a done strobe.
module seq_barrel_shifter_4bit #(
   parameter int WIDTH = 4,
   parameter int SHW   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] D,
   input  logic [SHW-1:0]   S,
   input  logic             dir,
   input  logic             mode,
   output logic [WIDTH-1:0] Y,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] wr_q, wr_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_left, step_right;

   // Fill bit is the wrapped-around bit for rotate, zero for logical shift.
   assign step_left  = {wr_q[WIDTH-2:0], (mode_q ? 1'b0 : wr_q[WIDTH-1])};
   assign step_right = {(mode_q ? 1'b0 : wr_q[0]), wr_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      y_d     = y_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               wr_d    = D;
               cnt_d   = S;
               dir_d   = dir;
               mode_d  = mode;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               wr_d  = dir_q ? step_right : step_left;
               cnt_d = cnt_q - 1'b1;
            end else begin
               y_d     = wr_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wr_q    <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 1'b0;
         y_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Y    = y_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_seq_barrel_shifter_4bit.sv
// Directed bench for seq_barrel_shifter_4bit: rotate/shift vectors, latency,
// start-while-busy, back-to-back operation and asynchronous reset mid-operation.
module tb_seq_barrel_shifter_4bit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] D;
   logic [1:0] S;
   logic       dir;
   logic       mode;
   logic [3:0] Y;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;
   logic [3:0] prev_y = 4'b0000;

   seq_barrel_shifter_4bit #(.WIDTH(4), .SHW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .D     (D),
      .S     (S),
      .dir   (dir),
      .mode  (mode),
      .Y     (Y),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One operation; expects done exactly S+1 edges after the accept edge.
   task automatic do_op(input logic [3:0] d, input logic [1:0] s, input logic dr,
                        input logic md, input logic [3:0] ey, input string tag);
      int n;
      @(negedge clk);
      D = d; S = s; dir = dr; mode = md; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      D = 4'bxxxx; S = 2'b00; dir = ~dr; mode = ~md;
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_yhold"}, Y, prev_y);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 20);
      chk({tag, "_lat"}, n, s + 1);
      chk({tag, "_y"}, Y, ey);
      chk({tag, "_nbusy"}, busy, 1'b0);
      prev_y = Y;
      $display("op %s d=%b s=%0d dir=%0d mode=%0d y=%b lat=%0d", tag, d, s, dr, md, Y, n);
      @(negedge clk);
      chk({tag, "_done1"}, done, 1'b0);
      chk({tag, "_ystay"}, Y, ey);
   endtask

   initial begin
      int n, n1, n2, cnt_done;
      logic [3:0] y1, y2;
      rst_n = 1'b0; start = 1'b0; D = 4'b0; S = 2'b0; dir = 1'b0; mode = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_y", Y, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      rst_n = 1'b1;

      // rotate left
      do_op(4'b1101, 2'd0, 1'b0, 1'b0, 4'b1101, "rol0");
      do_op(4'b1101, 2'd1, 1'b0, 1'b0, 4'b1011, "rol1");
      do_op(4'b1101, 2'd2, 1'b0, 1'b0, 4'b0111, "rol2");
      do_op(4'b1101, 2'd3, 1'b0, 1'b0, 4'b1110, "rol3");
      // rotate right and round trip back left
      do_op(4'b1101, 2'd1, 1'b1, 1'b0, 4'b1110, "ror1");
      do_op(4'b1110, 2'd1, 1'b0, 1'b0, 4'b1101, "rt1");
      do_op(4'b1101, 2'd2, 1'b1, 1'b0, 4'b0111, "ror2");
      do_op(4'b0111, 2'd2, 1'b0, 1'b0, 4'b1101, "rt2");
      do_op(4'b1101, 2'd3, 1'b1, 1'b0, 4'b1011, "ror3");
      do_op(4'b1011, 2'd3, 1'b0, 1'b0, 4'b1101, "rt3");
      // logical shifts
      do_op(4'b1101, 2'd2, 1'b0, 1'b1, 4'b0100, "shl2");
      do_op(4'b1101, 2'd1, 1'b1, 1'b1, 4'b0110, "shr1");
      do_op(4'b1101, 2'd3, 1'b1, 1'b1, 4'b0001, "shr3");

      // start while busy: second request must be dropped
      @(negedge clk);
      D = 4'b1101; S = 2'd3; dir = 1'b0; mode = 1'b0; start = 1'b1;
      @(negedge clk);
      D = 4'b0000;
      @(negedge clk);
      start = 1'b0;
      cnt_done = 0;
      for (int i = 0; i < 14; i++) begin
         if (done) begin
            cnt_done++;
            chk("sbusy_y", Y, 4'b1110);
         end
         @(negedge clk);
      end
      chk("sbusy_ndone", cnt_done, 1);
      chk("sbusy_idle", busy, 1'b0);
      chk("sbusy_yfinal", Y, 4'b1110);
      $display("op sbusy y=%b dones=%0d", Y, cnt_done);

      // back-to-back with start held high
      @(negedge clk);
      D = 4'b0001; S = 2'd1; dir = 1'b0; mode = 1'b0; start = 1'b1;
      n = 0; n1 = -1; n2 = -1; y1 = 4'b0; y2 = 4'b0;
      while (n2 < 0 && n < 30) begin
         @(negedge clk);
         n++;
         if (done) begin
            if (n1 < 0) begin
               n1 = n; y1 = Y; D = 4'b0010;
            end else begin
               n2 = n; y2 = Y; start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk("b2b_y1", y1, 4'b0010);
      chk("b2b_y2", y2, 4'b0100);
      chk("b2b_gap", n2 - n1, 3);
      $display("op b2b y1=%b y2=%b gap=%0d", y1, y2, n2 - n1);
      repeat (4) @(negedge clk);
      chk("b2b_stop", busy, 1'b0);

      // asynchronous reset mid-operation
      @(negedge clk);
      D = 4'b1101; S = 2'd3; dir = 1'b0; mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_y", Y, 4'b0000);
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) cnt_done++;
      end
      chk("arst_nodone", cnt_done, 0);
      chk("arst_ykeep", Y, 4'b0000);
      $display("op arst y=%b dones=%0d", Y, cnt_done);
      prev_y = 4'b0000;
      do_op(4'b1101, 2'd2, 1'b0, 1'b0, 4'b0111, "post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
